// File: rtl/vga_input_conditioner_if.sv
// Raw switch/button/radio inputs and conditioned outputs of the VGA input front-end.
// The master side drives the raw inputs; the slave side conditions them.
interface vga_input_conditioner_if;
   logic       sw_left;
   logic       sw_right;
   logic       sw_up;
   logic       sw_down;
   logic       sw_return;
   logic       screensaver;
   logic       stretch;
   logic [3:0] radio;
   logic [6:0] lvl;
   logic [6:0] press;
   logic [3:0] move;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic [3:0] radio_q;
   logic       radio_chg;

   modport master (
      output sw_left, sw_right, sw_up, sw_down, sw_return, screensaver, stretch, radio,
      input  lvl, press, move, cmd, cmd_valid, radio_q, radio_chg
   );

   modport slave (
      input  sw_left, sw_right, sw_up, sw_down, sw_return, screensaver, stretch, radio,
      output lvl, press, move, cmd, cmd_valid, radio_q, radio_chg
   );
endinterface

// File: rtl/vga_input_conditioner.sv
// Synchronises and debounces the VGA controller's switches, buttons and radio selector,
// producing press pulses, auto-repeating direction moves and a priority-encoded command.
module vga_input_conditioner #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int REPEAT_DELAY = 50_000_000,
   parameter int REPEAT_RATE  = 10_000_000,
   parameter int CNT_W        = 27
) (
   input logic                    clk,
   input logic                    rst,
   vga_input_conditioner_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

   localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_TC  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_TC = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [6:0]       raw, sync_p0, sync_p1;
   logic [6:0]       lvl, lvl_nx, rise;
   logic [CNT_W-1:0] dcnt [7];
   logic [3:0]       radio_p0, radio_p1, radio_p2, radio_q;
   logic [CNT_W-1:0] rdcnt;
   rep_state_t       rstate [4];
   logic [CNT_W-1:0] rcnt [4];
   logic [3:0]       rep_hit, move_nx;
   logic [2:0]       cmd_nx;
   logic [6:0]       press;
   logic [3:0]       move;
   logic [2:0]       cmd;
   logic             cmd_valid, radio_chg;

   // Bit i of the combined press/move vector maps to command code i+1.
   function automatic logic [2:0] encode_cmd(input logic [6:0] pr, input logic [3:0] mv);
      if (pr[4])      return 3'd5;
      else if (pr[5]) return 3'd6;
      else if (pr[6]) return 3'd7;
      else if (mv[0]) return 3'd1;
      else if (mv[1]) return 3'd2;
      else if (mv[2]) return 3'd3;
      else if (mv[3]) return 3'd4;
      else            return 3'd0;
   endfunction

   assign raw = {bus.stretch, bus.screensaver, bus.sw_return,
                 bus.sw_down, bus.sw_up, bus.sw_right, bus.sw_left};

   assign bus.lvl       = lvl;
   assign bus.press     = press;
   assign bus.move      = move;
   assign bus.cmd       = cmd;
   assign bus.cmd_valid = cmd_valid;
   assign bus.radio_q   = radio_q;
   assign bus.radio_chg = radio_chg;

   always_comb begin
      lvl_nx = lvl;
      for (int i = 0; i < 7; i++)
         if (sync_p1[i] != lvl[i] && dcnt[i] == DEB_TC) lvl_nx[i] = sync_p1[i];
   end

   assign rise = lvl_nx & ~lvl;

   // A release on the same edge as a terminal count suppresses the repeat.
   always_comb begin
      rep_hit = '0;
      for (int i = 0; i < 4; i++)
         if (lvl_nx[i] && !rise[i])
            case (rstate[i])
               DELAY:   rep_hit[i] = (rcnt[i] == DLY_TC);
               REPEAT:  rep_hit[i] = (rcnt[i] == RATE_TC);
               default: rep_hit[i] = 1'b0;
            endcase
   end

   assign move_nx = rise[3:0] | rep_hit;
   assign cmd_nx  = encode_cmd(rise, move_nx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_p0   <= '0;
         sync_p1   <= '0;
         radio_p0  <= '0;
         radio_p1  <= '0;
         radio_p2  <= '0;
         lvl       <= '0;
         press     <= '0;
         move      <= '0;
         cmd       <= '0;
         cmd_valid <= 1'b0;
         radio_q   <= '0;
         radio_chg <= 1'b0;
         rdcnt     <= '0;
         for (int i = 0; i < 7; i++) dcnt[i] <= '0;
         for (int i = 0; i < 4; i++) begin
            rstate[i] <= IDLE;
            rcnt[i]   <= '0;
         end
      end else begin
         // p0/p1: two-flop synchroniser; p2 remembers the previous radio sample
         sync_p0  <= raw;
         sync_p1  <= sync_p0;
         radio_p0 <= bus.radio;
         radio_p1 <= radio_p0;
         radio_p2 <= radio_p1;

         for (int i = 0; i < 7; i++)
            if (sync_p1[i] == lvl[i] || dcnt[i] == DEB_TC) dcnt[i] <= '0;
            else                                           dcnt[i] <= dcnt[i] + CNT_ONE;

         lvl       <= lvl_nx;
         press     <= rise;
         move      <= move_nx;
         cmd       <= cmd_nx;
         cmd_valid <= (cmd_nx != 3'd0);

         for (int i = 0; i < 4; i++)
            if (!lvl_nx[i]) begin
               rstate[i] <= IDLE;
               rcnt[i]   <= '0;
            end else if (rise[i]) begin
               rstate[i] <= DELAY;
               rcnt[i]   <= '0;
            end else if (rep_hit[i]) begin
               rstate[i] <= REPEAT;
               rcnt[i]   <= '0;
            end else if (rstate[i] != IDLE) begin
               rcnt[i]   <= rcnt[i] + CNT_ONE;
            end

         // A fresh radio value counts as its first stable sample.
         radio_chg <= 1'b0;
         if (radio_p1 == radio_q) begin
            rdcnt <= '0;
         end else if (radio_p1 != radio_p2) begin
            rdcnt <= CNT_ONE;
         end else if (rdcnt == DEB_TC) begin
            rdcnt     <= '0;
            radio_q   <= radio_p1;
            radio_chg <= 1'b1;
         end else begin
            rdcnt <= rdcnt + CNT_ONE;
         end
      end
   end
endmodule

// File: tb/tb_vga_input_conditioner.sv
// Randomised and directed bench for vga_input_conditioner, compared cycle by cycle
// against a window-based reference model of debounce, repeat timing and priority.
module tb_vga_input_conditioner;
   localparam int D    = 16;
   localparam int RD   = 64;
   localparam int RR   = 16;
   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_input_conditioner_if bus();

   vga_input_conditioner #(
      .DEBOUNCE_CYC(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   logic [10:0] raw_hist [MAXC];
   bit          rst_hist [MAXC];

   logic [6:0] m_lvl;
   logic [3:0] m_rq;
   int         m_ptime [4];
   logic [6:0] e_lvl, e_press;
   logic [3:0] e_move, e_rq;
   logic [2:0] e_cmd;
   logic       e_cv, e_chg;

   int seg_base;
   int cnt_press [7];
   int cnt_lvl [7];
   int cnt_move [4];
   int cnt_cmd [8];
   int first_press [7];
   int cnt_chg, first_chg, first_cmd, first_cmd_code;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
   endtask

   // Value the debouncer examines at edge t: the input of cycle t-3, unless a reset
   // cleared the synchroniser in between.
   function automatic logic [10:0] rd(input int t);
      if (t - 3 < 0) return '0;
      if (!rst_hist[t-3] || !rst_hist[t-2]) return '0;
      return raw_hist[t-3];
   endfunction

   task automatic model(input int c);
      logic [6:0] old;
      logic [6:0] fire;
      logic [3:0] vr;
      bit         all_flip, same;
      int         order [7];
      order = '{4, 5, 6, 0, 1, 2, 3};
      if (c == 0 || !rst_hist[c] || !rst_hist[c-1]) begin
         m_lvl = '0; m_rq = '0;
         e_lvl = '0; e_press = '0; e_move = '0; e_cmd = '0; e_cv = 1'b0;
         e_rq = '0; e_chg = 1'b0;
         return;
      end
      // A level flips once the last D examined samples all disagree with it.
      old = m_lvl;
      for (int i = 0; i < 7; i++) begin
         all_flip = 1;
         for (int k = 0; k < D; k++) if (rd(c - k)[i] == m_lvl[i]) all_flip = 0;
         if (all_flip) m_lvl[i] = ~m_lvl[i];
      end
      e_lvl   = m_lvl;
      e_press = m_lvl & ~old;
      for (int i = 0; i < 4; i++) begin
         if (e_press[i]) m_ptime[i] = c;
         e_move[i] = e_press[i] ||
                     (m_lvl[i] && (c - m_ptime[i]) >= RD && ((c - m_ptime[i] - RD) % RR) == 0);
      end
      fire  = {e_press[6:4], e_move};
      e_cmd = '0;
      for (int j = 6; j >= 0; j--) if (fire[order[j]]) e_cmd = 3'(order[j] + 1);
      e_cv = (e_cmd != 0);
      vr   = rd(c)[10:7];
      same = 1;
      for (int k = 1; k < D; k++) if (rd(c - k)[10:7] != vr) same = 0;
      e_chg = same && (vr != m_rq);
      if (e_chg) m_rq = vr;
      e_rq = m_rq;
   endtask

   task automatic tally_clear();
      seg_base = cyc;
      for (int i = 0; i < 7; i++) begin cnt_press[i] = 0; cnt_lvl[i] = 0; first_press[i] = -1; end
      for (int i = 0; i < 4; i++) cnt_move[i] = 0;
      for (int i = 0; i < 8; i++) cnt_cmd[i] = 0;
      cnt_chg = 0; first_chg = -1; first_cmd = -1; first_cmd_code = 0;
   endtask

   task automatic step(input logic [6:0] sw, input logic [3:0] rad, input logic r);
      @(posedge clk);
      #1;
      {bus.stretch, bus.screensaver, bus.sw_return, bus.sw_down,
       bus.sw_up, bus.sw_right, bus.sw_left} = sw;
      bus.radio = rad;
      rst = r;
      raw_hist[cyc] = {rad, sw};
      rst_hist[cyc] = r;
      model(cyc);
      @(negedge clk);
      chk("lvl", 32'(bus.lvl), 32'(e_lvl));
      chk("press", 32'(bus.press), 32'(e_press));
      chk("move", 32'(bus.move), 32'(e_move));
      chk("cmd", 32'(bus.cmd), 32'(e_cmd));
      chk("cmd_valid", 32'(bus.cmd_valid), 32'(e_cv));
      chk("radio_q", 32'(bus.radio_q), 32'(e_rq));
      chk("radio_chg", 32'(bus.radio_chg), 32'(e_chg));
      for (int i = 0; i < 7; i++) begin
         if (bus.lvl[i]) cnt_lvl[i]++;
         if (bus.press[i]) begin
            cnt_press[i]++;
            if (first_press[i] < 0) first_press[i] = cyc - seg_base;
         end
      end
      for (int i = 0; i < 4; i++) if (bus.move[i]) cnt_move[i]++;
      if (bus.cmd_valid) begin
         cnt_cmd[bus.cmd]++;
         if (first_cmd < 0) begin first_cmd = cyc - seg_base; first_cmd_code = bus.cmd; end
      end
      if (bus.radio_chg) begin
         cnt_chg++;
         if (first_chg < 0) first_chg = cyc - seg_base;
      end
      cyc++;
   endtask

   task automatic hold(input int n, input logic [6:0] sw, input logic [3:0] rad, input logic r);
      for (int i = 0; i < n; i++) step(sw, rad, r);
   endtask

   initial begin
      logic [6:0] cur_sw;
      logic [3:0] cur_rad;
      logic       r;
      int         rst_left;
      rst = 1'b0;
      {bus.stretch, bus.screensaver, bus.sw_return, bus.sw_down,
       bus.sw_up, bus.sw_right, bus.sw_left} = '0;
      bus.radio = '0;
      for (int i = 0; i < 4; i++) m_ptime[i] = 0;

      tally_clear();
      hold(5, 7'h00, 4'h0, 1'b0);
      chk("reset_lvl", 32'(bus.lvl), 32'h0);
      chk("reset_radio_q", 32'(bus.radio_q), 32'h0);
      hold(5, 7'h00, 4'h0, 1'b1);

      // left held 200 cycles: press at 18, ten moves, level high 200 cycles
      tally_clear();
      hold(200, 7'h01, 4'h0, 1'b1);
      hold(40, 7'h00, 4'h0, 1'b1);
      chk("t1_press_ofs", 32'(first_press[0]), 32'd18);
      chk("t1_press_cnt", 32'(cnt_press[0]), 32'd1);
      chk("t1_move_cnt", 32'(cnt_move[0]), 32'd10);
      chk("t1_cmd1_cnt", 32'(cnt_cmd[1]), 32'd10);
      chk("t1_lvl_cycles", 32'(cnt_lvl[0]), 32'd200);

      // up glitch shorter than the debounce window
      tally_clear();
      hold(10, 7'h04, 4'h0, 1'b1);
      hold(30, 7'h00, 4'h0, 1'b1);
      chk("t2_lvl_cycles", 32'(cnt_lvl[2]), 32'd0);
      chk("t2_cmd_count", 32'(first_cmd), 32'hffffffff);

      // left and return together: return wins the command
      tally_clear();
      hold(30, 7'h11, 4'h0, 1'b1);
      hold(40, 7'h00, 4'h0, 1'b1);
      chk("t3_press0_ofs", 32'(first_press[0]), 32'd18);
      chk("t3_press4_ofs", 32'(first_press[4]), 32'd18);
      chk("t3_cmd_ofs", 32'(first_cmd), 32'd18);
      chk("t3_cmd_code", 32'(first_cmd_code), 32'd5);

      // right held through a 3-cycle reset
      hold(40, 7'h02, 4'h0, 1'b1);
      tally_clear();
      hold(3, 7'h02, 4'h0, 1'b0);
      chk("t4_rst_lvl", 32'(cnt_lvl[1]), 32'd0);
      tally_clear();
      hold(40, 7'h02, 4'h0, 1'b1);
      hold(30, 7'h00, 4'h0, 1'b1);
      chk("t4_repress_ofs", 32'(first_press[1]), 32'd18);

      // radio step with a short bounce
      tally_clear();
      hold(60, 7'h00, 4'h8, 1'b1);
      hold(3, 7'h00, 4'h0, 1'b1);
      hold(40, 7'h00, 4'h8, 1'b1);
      chk("t5_chg_cnt", 32'(cnt_chg), 32'd1);
      chk("t5_chg_ofs", 32'(first_chg), 32'd18);
      chk("t5_radio_q", 32'(bus.radio_q), 32'h8);

      // stretch never repeats
      tally_clear();
      hold(500, 7'h40, 4'h8, 1'b1);
      hold(40, 7'h00, 4'h8, 1'b1);
      chk("t6_press_cnt", 32'(cnt_press[6]), 32'd1);
      chk("t6_press_ofs", 32'(first_press[6]), 32'd18);
      chk("t6_cmd7_cnt", 32'(cnt_cmd[7]), 32'd1);

      cur_sw   = '0;
      cur_rad  = 4'h8;
      rst_left = 0;
      for (int n = 0; n < 2000; n++) begin
         for (int b = 0; b < 7; b++)
            if ($urandom_range(b < 4 ? 59 : 23) == 0) cur_sw[b] = ~cur_sw[b];
         if ($urandom_range(29) == 0) cur_rad = 4'($urandom);
         if (rst_left > 0) begin
            r = 1'b0;
            rst_left--;
         end else if ($urandom_range(599) == 0) begin
            r = 1'b0;
            rst_left = $urandom_range(2);
         end else begin
            r = 1'b1;
         end
         step(cur_sw, cur_rad, r);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
